// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall sequencer.
//   state_t   : sequencer state (RUN, MD_BUSY)
//   REG_W_DEF : default register specifier width
//   ZERO_REG  : register $0, which never produces a load-use hazard
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam int REG_W_DEF = 5;

    localparam logic [REG_W_DEF-1:0] ZERO_REG = '0;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use comparator.
// Flags when the load currently in EX writes a register that the
// instruction in ID reads. A load into $0 is never a hazard.
// Ports:
//   id_rs, id_rt           : source specifiers of the ID instruction
//   id_uses_rs, id_uses_rt : qualifiers, the ID instruction really reads them
//   ex_memread             : EX holds a load
//   ex_rt                  : destination of that load
//   load_use               : hazard present this cycle
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    output logic             load_use
);

    logic dst_live;
    logic rs_match;
    logic rt_match;

    always_comb begin
        dst_live = ex_memread && (ex_rt != REG_W'(ZERO_REG));
        rs_match = id_uses_rs && (id_rs == ex_rt);
        rt_match = id_uses_rt && (id_rt == ex_rt);
        load_use = dst_live && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline.
// Produces enable/flush controls for the PC and the four inter-stage
// register banks. Controls are combinational from the registered state
// and the current inputs so they act in the same cycle.
// Priority (highest first): reset, mem_wait freeze, mult/div stall,
// mult/div release, taken branch, load-use bubble.
// Ports:
//   clk, arst            : clock, synchronous active-high reset
//   mem_wait             : memory not ready, freeze everything
//   id_*/ex_memread/ex_rt: load-use hazard inputs
//   ex_branch_taken      : taken branch/jump resolved in EX
//   ex_muldiv            : EX holds a mult/div
//   *_en, *_flush        : register bank enables and bubble loads
//   muldiv_busy/done     : mult/div occupancy status and release pulse
//   stall_cycles         : saturating count of cycles with pc_en=0
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int REG_W   = REG_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             mem_wait,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_muldiv,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             muldiv_busy,
    output logic             muldiv_done,
    output logic [CNT_W-1:0] stall_cycles
);

    // The cycle that launches the mult/div and the release cycle both
    // count toward MUL_LAT, so the busy countdown starts at MUL_LAT-2.
    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);

    state_t     state;
    logic [3:0] cnt;
    logic       load_use;
    logic       md_stall;
    logic       md_release;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .load_use   (load_use)
    );

    always_comb begin
        md_stall   = ((state == RUN) && ex_muldiv) ||
                     ((state == MD_BUSY) && (cnt != 4'd0));
        md_release = (state == MD_BUSY) && (cnt == 4'd0);
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        muldiv_busy = (state == MD_BUSY);
        muldiv_done = 1'b0;

        if (arst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            exmem_flush = 1'b1;
            memwb_en    = 1'b0;
            muldiv_busy = 1'b0;
        end else if (mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (md_stall) begin
            // Hold IF/ID/EX; a bubble drains into MEM behind the mult/div.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
        end else if (md_release) begin
            muldiv_done = 1'b1;
        end else if (ex_branch_taken) begin
            // The ID instruction is squashed, so any load-use match is moot.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state        <= RUN;
            cnt          <= 4'd0;
            stall_cycles <= '0;
        end else begin
            if (!pc_en) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            // mem_wait freezes the mult/div countdown.
            if (!mem_wait) begin
                if (md_stall) begin
                    if (state == RUN) begin
                        cnt   <= CNT_INIT;
                        state <= MD_BUSY;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end else if (md_release) begin
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    localparam int MUL_LAT = 4;
    localparam int REG_W   = 5;
    localparam int CNT_W   = 4;
    localparam int SAT     = (1 << CNT_W) - 1;

    typedef struct {
        bit             arst;
        bit             mem_wait;
        bit [REG_W-1:0] id_rs;
        bit [REG_W-1:0] id_rt;
        bit             uses_rs;
        bit             uses_rt;
        bit             ex_memread;
        bit [REG_W-1:0] ex_rt;
        bit             branch;
        bit             muldiv;
    } stim_t;

    typedef struct {
        logic [9:0]       ctl;
        logic [9:0]       mask;
        logic [CNT_W-1:0] st;
        int               cyc;
    } exp_t;

    logic             clk;
    logic             arst;
    logic             mem_wait;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rt;
    logic             ex_branch_taken;
    logic             ex_muldiv;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             memwb_en;
    logic             muldiv_busy;
    logic             muldiv_done;
    logic [CNT_W-1:0] stall_cycles;

    pipe_stall_ctrl #(
        .MUL_LAT (MUL_LAT),
        .REG_W   (REG_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk             (clk),
        .arst            (arst),
        .mem_wait        (mem_wait),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .ex_muldiv       (ex_muldiv),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .exmem_flush     (exmem_flush),
        .memwb_en        (memwb_en),
        .muldiv_busy     (muldiv_busy),
        .muldiv_done     (muldiv_done),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   drv_done = 0;
    bit   mon_done = 0;

    // Reference state: EX cycles the current mult/div still needs
    // (0 = none in flight) and the ideal stall count.
    int   m_left = 0;
    int   m_stalls = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic model(input stim_t s, output exp_t e);
        bit pc, ie, ifl, de, dfl, xe, xfl, we, busy, done, lu;
        pc = 1; ie = 1; ifl = 0; de = 1; dfl = 0; xe = 1; xfl = 0; we = 1;
        busy = (m_left > 0);
        done = 0;
        e.st = CNT_W'(m_stalls);
        lu = s.ex_memread && (s.ex_rt != 0) &&
             ((s.uses_rs && s.id_rs == s.ex_rt) || (s.uses_rt && s.id_rt == s.ex_rt));
        if (s.arst) begin
            pc = 0; ie = 0; ifl = 1; de = 0; dfl = 1; xe = 0; xfl = 1; we = 0;
            busy = 0;
            m_left = 0;
            m_stalls = 0;
        end else begin
            if (s.mem_wait) begin
                pc = 0; ie = 0; de = 0; xe = 0; we = 0;
            end else if (m_left > 1 || (m_left == 0 && s.muldiv)) begin
                pc = 0; ie = 0; de = 0; xfl = 1;
                m_left = (m_left == 0) ? MUL_LAT - 1 : m_left - 1;
            end else if (m_left == 1) begin
                done = 1;
                m_left = 0;
            end else if (s.branch) begin
                ifl = 1; dfl = 1;
            end else if (lu) begin
                pc = 0; ie = 0; dfl = 1;
            end
            if (!pc && m_stalls < SAT) m_stalls++;
        end
        e.ctl  = {pc, ie, ifl, de, dfl, xe, xfl, we, busy, done};
        // A flushed stage's enable does not matter.
        e.mask = {1'b1, !ifl, 1'b1, !dfl, 1'b1, !xfl, 3'b111};
        e.cyc  = cyc;
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        arst            = s.arst;
        mem_wait        = s.mem_wait;
        id_rs           = s.id_rs;
        id_rt           = s.id_rt;
        id_uses_rs      = s.uses_rs;
        id_uses_rt      = s.uses_rt;
        ex_memread      = s.ex_memread;
        ex_rt           = s.ex_rt;
        ex_branch_taken = s.branch;
        ex_muldiv       = s.muldiv;
        model(s, e);
        q.push_back(e);
    endtask

    // Monitor: compares every presented cycle against the queued expectation.
    initial begin
        exp_t       e;
        logic [9:0] act;
        int         guard;
        guard = 0;
        while (!(drv_done && q.size() == 0) && guard < 50000) begin
            @(negedge clk);
            guard++;
            if (q.size() > 0) begin
                e = q.pop_front();
                act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                       exmem_en, exmem_flush, memwb_en, muldiv_busy, muldiv_done};
                total++;
                if ((act & e.mask) !== (e.ctl & e.mask)) begin
                    bad++;
                    $display("FAIL ctl cycle=%0d actual=%b required=%b mask=%b",
                             e.cyc, act, e.ctl, e.mask);
                end
                total++;
                if (stall_cycles !== e.st) begin
                    bad++;
                    $display("FAIL stall_cycles cycle=%0d actual=%0d required=%0d",
                             e.cyc, stall_cycles, e.st);
                end
            end
        end
        if (guard >= 50000) begin
            total++;
            bad++;
            $display("FAIL monitor_timeout actual=%0d pending required=0", q.size());
        end
        mon_done = 1;
    end

    initial begin
        stim_t s;
        arst = 1; mem_wait = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_memread = 0; ex_rt = 0; ex_branch_taken = 0; ex_muldiv = 0;
        repeat (2) @(posedge clk);

        // Reset state
        s = idle(); s.arst = 1; step(s);
        step(idle());

        // Load-use on rs
        s = idle(); s.ex_memread = 1; s.ex_rt = 8; s.id_rs = 8; s.uses_rs = 1; step(s);
        step(idle());
        // Load-use on rt
        s = idle(); s.ex_memread = 1; s.ex_rt = 3; s.id_rt = 3; s.uses_rt = 1; step(s);
        // Register zero never stalls
        s = idle(); s.ex_memread = 1; s.ex_rt = 0; s.id_rs = 0; s.uses_rs = 1; step(s);
        // Match without the read qualifier
        s = idle(); s.ex_memread = 1; s.ex_rt = 8; s.id_rs = 8; step(s);
        // Branch overrides load-use
        s = idle(); s.ex_memread = 1; s.ex_rt = 8; s.id_rs = 8; s.uses_rs = 1; s.branch = 1; step(s);
        step(idle());

        // Mult/div held for MUL_LAT cycles
        s = idle(); s.muldiv = 1;
        repeat (MUL_LAT) step(s);
        step(idle());

        // mem_wait during MD_BUSY stretches occupancy
        s = idle(); s.muldiv = 1; step(s);
        s.mem_wait = 1; step(s); step(s);
        s.mem_wait = 0; step(s); step(s); step(s);
        step(idle());

        // Reset in the middle of MD_BUSY
        s = idle(); s.muldiv = 1; step(s); step(s);
        s = idle(); s.arst = 1; step(s);
        step(idle()); step(idle());

        // Saturation
        s = idle(); s.mem_wait = 1;
        repeat (20) step(s);
        step(idle()); step(idle());

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.arst       = ($urandom_range(0, 59) == 0);
            s.mem_wait   = ($urandom_range(0, 7) == 0);
            s.id_rs      = REG_W'($urandom_range(0, 3));
            s.id_rt      = REG_W'($urandom_range(0, 3));
            s.uses_rs    = $urandom_range(0, 1);
            s.uses_rt    = $urandom_range(0, 1);
            s.ex_memread = ($urandom_range(0, 2) == 0);
            s.ex_rt      = REG_W'($urandom_range(0, 3));
            s.branch     = ($urandom_range(0, 5) == 0);
            s.muldiv     = ($urandom_range(0, 9) == 0);
            step(s);
        end
        step(idle());
        drv_done = 1;

        wait (mon_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
